link_port_arbiter: RTL and testbench
====================================

# link_port_arbiter

Shares the single physical link-port pin set between the emulated core's serial unit and a host-side byte engine (ESP32 bridge: printer/Wi-Fi link emulation). An ownership state machine grants the pins to one side at a time, switching only at byte boundaries after a guard interval of idle bus. When the host owns the port, the arbiter clocks one byte as internal-clock master. Sits between the core serial unit and the top-level pin drivers.

## Interface
- HOST_HALF_DIV, 9'd255: ce ticks per half SCK period for host transfers (full bit = 2*(HOST_HALF_DIV+1) ticks)
- GUARD_TICKS, 8'd16: ce ticks of idle bus required before any ownership change
- clk_sys  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable; all state advances only when ce=1 (except reset)
- core_clk_out  in  1  core serial clock output
- core_data_out  in  1  core serial data output
- core_busy  in  1  core transfer active (SC bit 7)
- core_int_clock  in  1  core is clock master
- core_clk_in  out  1  clock presented to core
- core_data_in  out  1  data presented to core
- host_req  in  1  host byte request, level; held until host_ack
- host_tx  in  8  byte to send, sampled on accept
- host_ack  out  1  one-ce-tick pulse: request accepted
- host_done  out  1  one-ce-tick pulse: byte complete, host_rx valid
- host_rx  out  8  byte received from partner
- pin_clk_in  in  1  physical SCK input
- pin_data_in  in  1  physical SIN
- pin_clk_out  out  1  physical SCK output
- pin_clk_oe  out  1  SCK output enable (1 = drive)
- pin_data_out  out  1  physical SOUT
- owner_host  out  1  status: host holds the port

## Operation
- States: CORE, GUARD_TO_HOST, HOST_XFER, GUARD_TO_CORE.
- CORE: pins mirror core (pin_clk_out=core_clk_out, pin_data_out=core_data_out, pin_clk_oe=core_busy&core_int_clock); core_clk_in=pin_clk_in, core_data_in=pin_data_in.
- CORE -> GUARD_TO_HOST when host_req=1, core_busy=0, pin_clk_in=1. Guard counter loads GUARD_TICKS, decrements per ce.
- GUARD_TO_HOST: core_busy rising or pin_clk_in falling -> back to CORE, counter cleared, no ack. Counter reaching 0 -> HOST_XFER, host_ack pulse, host_tx latched, bit counter=8, divider=HOST_HALF_DIV.
- HOST_XFER: pin_clk_oe=1. Per bit: SCK low for HOST_HALF_DIV+1 ticks, pin_data_out=shift[7] set on falling edge; SCK high for HOST_HALF_DIV+1 ticks, pin_data_in shifted into LSB on rising edge. MSB first. After 8th rising edge: host_rx=shift, host_done pulse, -> GUARD_TO_CORE.
- Core isolation during host ownership: core_clk_in=1, core_data_in=1 (disconnected-cable behaviour; core internal-clock transfer started now receives 8'hFF).
- GUARD_TO_CORE: SCK high, oe=1 for GUARD_TICKS, then -> CORE. Fairness: if core_busy=1 at entry, next host_req is not considered until core_busy falls.
- Divider and counters 9/8/4 bits, no wrap: terminal count 0 reloads.

## Timing
- Reset values: state CORE, pin_clk_out=1, pin_data_out=1, pin_clk_oe=0, host_ack=0, host_done=0, host_rx=8'h00, owner_host=0, counters 0.
- Pin muxing in CORE is combinational (0-cycle latency); all else registered.
- host_ack arrives GUARD_TICKS+1 ce ticks after the qualifying host_req sample.
- Host byte: host_done 16*(HOST_HALF_DIV+1) ce ticks after host_ack.
- host_req dropped before ack: guard aborts to CORE. host_req dropped after ack: transfer completes.
- Reset mid-transfer: immediate return to reset values, no host_done.
- host_req and core_busy rising same tick in CORE: core wins, stay CORE.

## Structure
- Package link_pkg: owner state enum, SCK/SOUT idle levels (1), bit count constant 8.
- Sub-module link_host_shifter: divider, bit counter, shift register, done pulse; arbiter FSM instantiates it.

## Test plan
- Reset -> pin_clk_out=1, pin_data_out=1, pin_clk_oe=0, owner_host=0.
- Idle bus, host_req with host_tx=8'hA5, partner loops SOUT->SIN -> host_ack after 17 ticks, 8 SCK pulses, host_rx=8'hA5, host_done one tick.
- core_busy=1 during host_req -> no ack until core_busy falls plus guard; core transfer undisturbed.
- core_busy rises mid-guard -> return CORE, no host_ack, later retry succeeds.
- Core internal-clock start during HOST_XFER -> core_data_in=1, core_clk_in=1; after handoff pins mirror core.
- rst asserted at bit 4 of host byte -> outputs at reset values next cycle, no host_done.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types and constants for the link-port arbiter and its host byte shifter.
package link_pkg;

    typedef enum logic [1:0] {
        ST_CORE,
        ST_GUARD_TO_HOST,
        ST_HOST_XFER,
        ST_GUARD_TO_CORE
    } owner_state_t;

    localparam logic       SCK_IDLE  = 1'b1;
    localparam logic       SOUT_IDLE = 1'b1;
    localparam logic [3:0] BIT_COUNT = 4'd8;

endpackage

// File: rtl/link_host_shifter.sv
// Internal-clock master for one host byte: SCK divider, bit counter, MSB-first shifter.
module link_host_shifter
    import link_pkg::*;
#(
    parameter logic [8:0] HALF_DIV = 9'd255
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       ce,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic       sin,
    output logic       sck,
    output logic       sout,
    output logic       done,
    output logic [7:0] rx
);

    logic       active_reg;
    logic       sck_reg;
    logic       sout_reg;
    logic       done_reg;
    logic [8:0] div_reg;
    logic [3:0] bit_reg;
    logic [7:0] shift_reg;
    logic [7:0] rx_reg;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            active_reg <= 1'b0;
            sck_reg    <= SCK_IDLE;
            sout_reg   <= SOUT_IDLE;
            done_reg   <= 1'b0;
            div_reg    <= 9'd0;
            bit_reg    <= 4'd0;
            shift_reg  <= 8'h00;
            rx_reg     <= 8'h00;
        end else if (ce) begin
            done_reg <= 1'b0;
            if (start) begin
                // Start is itself the first falling edge: MSB goes out immediately.
                active_reg <= 1'b1;
                shift_reg  <= tx;
                bit_reg    <= BIT_COUNT;
                div_reg    <= HALF_DIV;
                sck_reg    <= 1'b0;
                sout_reg   <= tx[7];
            end else if (active_reg) begin
                if (div_reg != 9'd0) begin
                    div_reg <= div_reg - 9'd1;
                end else begin
                    div_reg <= HALF_DIV;
                    if (!sck_reg) begin
                        sck_reg   <= 1'b1;
                        shift_reg <= {shift_reg[6:0], sin};
                        bit_reg   <= bit_reg - 4'd1;
                    end else if (bit_reg == 4'd0) begin
                        // Last high half-period complete: SCK stays idle-high.
                        active_reg <= 1'b0;
                        done_reg   <= 1'b1;
                        rx_reg     <= shift_reg;
                        sout_reg   <= SOUT_IDLE;
                        div_reg    <= 9'd0;
                    end else begin
                        sck_reg  <= 1'b0;
                        sout_reg <= shift_reg[7];
                    end
                end
            end
        end
    end

    assign sck  = sck_reg;
    assign sout = sout_reg;
    assign done = done_reg;
    assign rx   = rx_reg;

endmodule

// File: rtl/link_port_arbiter.sv
// Grants the shared link-port pins to either the core serial unit or the host byte engine,
// changing owner only at byte boundaries after a guard interval of idle bus.
module link_port_arbiter
    import link_pkg::*;
#(
    parameter logic [8:0] HOST_HALF_DIV = 9'd255,
    parameter logic [7:0] GUARD_TICKS   = 8'd16
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       ce,
    input  logic       core_clk_out,
    input  logic       core_data_out,
    input  logic       core_busy,
    input  logic       core_int_clock,
    output logic       core_clk_in,
    output logic       core_data_in,
    input  logic       host_req,
    input  logic [7:0] host_tx,
    output logic       host_ack,
    output logic       host_done,
    output logic [7:0] host_rx,
    input  logic       pin_clk_in,
    input  logic       pin_data_in,
    output logic       pin_clk_out,
    output logic       pin_clk_oe,
    output logic       pin_data_out,
    output logic       owner_host
);

    owner_state_t state_reg, state_next;
    logic [7:0]   guard_reg, guard_next;
    logic         ack_reg, ack_next;
    logic         start;
    logic         shift_sck;
    logic         shift_sout;
    logic         shift_done;

    link_host_shifter #(
        .HALF_DIV(HOST_HALF_DIV)
    ) u_shifter (
        .clk_sys(clk_sys),
        .rst    (rst),
        .ce     (ce),
        .start  (start),
        .tx     (host_tx),
        .sin    (pin_data_in),
        .sck    (shift_sck),
        .sout   (shift_sout),
        .done   (shift_done),
        .rx     (host_rx)
    );

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_reg <= ST_CORE;
            guard_reg <= 8'd0;
            ack_reg   <= 1'b0;
        end else if (ce) begin
            state_reg <= state_next;
            guard_reg <= guard_next;
            ack_reg   <= ack_next;
        end
    end

    // Requiring core_busy=0 to leave CORE also gives the core priority after a
    // host byte: a host request waits until any core transfer has finished.
    always_comb begin
        state_next = state_reg;
        guard_next = guard_reg;
        ack_next   = 1'b0;
        start      = 1'b0;
        case (state_reg)
            ST_CORE: begin
                if (host_req && !core_busy && pin_clk_in) begin
                    state_next = ST_GUARD_TO_HOST;
                    guard_next = GUARD_TICKS;
                end
            end
            ST_GUARD_TO_HOST: begin
                if (!host_req || core_busy || !pin_clk_in) begin
                    state_next = ST_CORE;
                    guard_next = 8'd0;
                end else if (guard_reg == 8'd0) begin
                    state_next = ST_HOST_XFER;
                    ack_next   = 1'b1;
                    start      = 1'b1;
                end else begin
                    guard_next = guard_reg - 8'd1;
                end
            end
            ST_HOST_XFER: begin
                if (shift_done) begin
                    state_next = ST_GUARD_TO_CORE;
                    guard_next = GUARD_TICKS;
                end
            end
            ST_GUARD_TO_CORE: begin
                if (guard_reg == 8'd0) begin
                    state_next = ST_CORE;
                end else begin
                    guard_next = guard_reg - 8'd1;
                end
            end
            default: state_next = ST_CORE;
        endcase
    end

    // While the host owns the port the core sees a disconnected cable (all ones).
    always_comb begin
        pin_clk_out  = core_clk_out;
        pin_data_out = core_data_out;
        pin_clk_oe   = core_busy & core_int_clock;
        core_clk_in  = pin_clk_in;
        core_data_in = pin_data_in;
        case (state_reg)
            ST_HOST_XFER: begin
                pin_clk_out  = shift_sck;
                pin_data_out = shift_sout;
                pin_clk_oe   = 1'b1;
                core_clk_in  = 1'b1;
                core_data_in = 1'b1;
            end
            ST_GUARD_TO_CORE: begin
                pin_clk_out  = SCK_IDLE;
                pin_data_out = SOUT_IDLE;
                pin_clk_oe   = 1'b1;
                core_clk_in  = 1'b1;
                core_data_in = 1'b1;
            end
            default: ;
        endcase
    end

    assign host_ack   = ack_reg;
    assign host_done  = shift_done;
    assign owner_host = (state_reg == ST_HOST_XFER) || (state_reg == ST_GUARD_TO_CORE);

endmodule

// File: tb/tb_link_port_arbiter.sv
// Scoreboard bench: the driver queues expected ack/done events, a negedge monitor checks them.
module tb_link_port_arbiter;

    logic       clk_sys = 1'b0;
    logic       rst;
    logic       ce;
    logic       core_clk_out;
    logic       core_data_out;
    logic       core_busy;
    logic       core_int_clock;
    logic       core_clk_in;
    logic       core_data_in;
    logic       host_req;
    logic [7:0] host_tx;
    logic       host_ack;
    logic       host_done;
    logic [7:0] host_rx;
    logic       pin_clk_in;
    logic       pin_data_in;
    logic       pin_clk_out;
    logic       pin_clk_oe;
    logic       pin_data_out;
    logic       owner_host;
    logic       invert;

    typedef struct {
        bit         is_done;
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   sck_rises = 0;
    logic sck_prev = 1'b1;
    logic ack_prev = 1'b0;
    logic done_prev = 1'b0;

    localparam int BYTE_TICKS = 16 * 256;
    localparam int ACK_DELAY  = 18;

    link_port_arbiter dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .ce            (ce),
        .core_clk_out  (core_clk_out),
        .core_data_out (core_data_out),
        .core_busy     (core_busy),
        .core_int_clock(core_int_clock),
        .core_clk_in   (core_clk_in),
        .core_data_in  (core_data_in),
        .host_req      (host_req),
        .host_tx       (host_tx),
        .host_ack      (host_ack),
        .host_done     (host_done),
        .host_rx       (host_rx),
        .pin_clk_in    (pin_clk_in),
        .pin_data_in   (pin_data_in),
        .pin_clk_out   (pin_clk_out),
        .pin_clk_oe    (pin_clk_oe),
        .pin_data_out  (pin_data_out),
        .owner_host    (owner_host)
    );

    // Partner: passive pull-up on SCK, SOUT looped (optionally inverted) back to SIN.
    assign pin_clk_in  = pin_clk_oe ? pin_clk_out : 1'b1;
    assign pin_data_in = invert ? ~pin_data_out : pin_data_out;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_sys) begin
        exp_t e;
        if (!rst) begin
            if (host_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", host_ack, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_kind", int'(e.is_done), 0);
                    check("ack_cycle", cyc, e.cyc);
                    $display("ack  cycle=%0d expected_cycle=%0d", cyc, e.cyc);
                end
            end
            if (host_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", host_done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_kind", int'(e.is_done), 1);
                    check("done_cycle", cyc, e.cyc);
                    check("host_rx", host_rx, e.data);
                    $display("done cycle=%0d rx=%02h expected=%02h", cyc, host_rx, e.data);
                end
            end
            if (ack_prev) check("ack_pulse_width", host_ack, 0);
            if (done_prev) check("done_pulse_width", host_done, 0);
            if (owner_host && pin_clk_out && !sck_prev) sck_rises++;
        end
        ack_prev  = host_ack;
        done_prev = host_done;
        sck_prev  = pin_clk_out;
    end

    task automatic push_xfer(input int c, input logic [7:0] rx_exp, input bit with_done);
        exp_t e;
        e.is_done = 1'b0;
        e.cyc     = c + ACK_DELAY;
        e.data    = 8'h00;
        exp_q.push_back(e);
        if (with_done) begin
            e.is_done = 1'b1;
            e.cyc     = c + ACK_DELAY + BYTE_TICKS;
            e.data    = rx_exp;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!host_ack && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        check("ack_seen", host_ack, 1);
        host_req = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!host_done && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        check("done_seen", host_done, 1);
    endtask

    task automatic wait_core();
        int n = 0;
        while (owner_host && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("handoff_to_core", owner_host, 0);
    endtask

    initial begin
        int c;
        int s0;
        rst = 1'b1; ce = 1'b1; invert = 1'b0;
        core_clk_out = 1'b1; core_data_out = 1'b1; core_busy = 1'b0; core_int_clock = 1'b0;
        host_req = 1'b0; host_tx = 8'h00;
        repeat (3) @(negedge clk_sys);
        check("rst_pin_clk_out", pin_clk_out, 1);
        check("rst_pin_data_out", pin_data_out, 1);
        check("rst_pin_clk_oe", pin_clk_oe, 0);
        check("rst_owner_host", owner_host, 0);
        check("rst_host_rx", host_rx, 8'h00);
        check("rst_host_ack", host_ack, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Idle-bus loopback byte.
        c = cyc;
        push_xfer(c, 8'hA5, 1'b1);
        s0 = sck_rises;
        host_tx = 8'hA5; host_req = 1'b1;
        wait_ack();
        wait_done();
        check("sck_pulses", sck_rises - s0, 8);
        wait_core();
        repeat (5) @(negedge clk_sys);

        // Inverting partner; core starts an internal-clock transfer mid-byte.
        invert = 1'b1;
        c = cyc;
        push_xfer(c, 8'hC3, 1'b1);
        host_tx = 8'h3C; host_req = 1'b1;
        wait_ack();
        repeat (300) @(negedge clk_sys);
        core_busy = 1'b1; core_int_clock = 1'b1; core_clk_out = 1'b0; core_data_out = 1'b0;
        @(negedge clk_sys);
        check("iso_core_clk_in", core_clk_in, 1);
        check("iso_core_data_in", core_data_in, 1);
        check("iso_pin_clk_oe", pin_clk_oe, 1);
        check("iso_owner_host", owner_host, 1);
        wait_done();
        wait_core();
        check("mirror_pin_clk_out", pin_clk_out, 0);
        check("mirror_pin_data_out", pin_data_out, 0);
        check("mirror_pin_clk_oe", pin_clk_oe, 1);
        check("mirror_core_clk_in", core_clk_in, 0);
        core_busy = 1'b0; core_int_clock = 1'b0; core_clk_out = 1'b1; core_data_out = 1'b1;
        invert = 1'b0;
        repeat (5) @(negedge clk_sys);

        // Host request while the core is busy: core keeps the pins.
        core_busy = 1'b1; core_int_clock = 1'b1; core_clk_out = 1'b0; core_data_out = 1'b0;
        @(negedge clk_sys);
        host_tx = 8'h5A; host_req = 1'b1;
        repeat (40) @(negedge clk_sys);
        check("busy_pin_clk_out", pin_clk_out, 0);
        check("busy_pin_clk_oe", pin_clk_oe, 1);
        check("busy_owner_host", owner_host, 0);
        core_busy = 1'b0; core_int_clock = 1'b0; core_clk_out = 1'b1; core_data_out = 1'b1;
        c = cyc;
        push_xfer(c, 8'h5A, 1'b1);
        wait_ack();
        wait_done();
        wait_core();
        repeat (5) @(negedge clk_sys);

        // Core goes busy in the middle of the guard: abort, then retry succeeds.
        host_tx = 8'hC3; host_req = 1'b1;
        repeat (5) @(negedge clk_sys);
        core_busy = 1'b1;
        repeat (30) @(negedge clk_sys);
        check("abort_owner_host", owner_host, 0);
        core_busy = 1'b0;
        c = cyc;
        push_xfer(c, 8'hC3, 1'b1);
        wait_ack();
        wait_done();
        wait_core();
        repeat (5) @(negedge clk_sys);

        // Reset around bit 4 of a host byte: no done, reset values restored.
        c = cyc;
        push_xfer(c, 8'h00, 1'b0);
        host_tx = 8'h81; host_req = 1'b1;
        wait_ack();
        repeat (4 * 512 + 100) @(negedge clk_sys);
        check("pre_rst_owner_host", owner_host, 1);
        rst = 1'b1;
        @(negedge clk_sys);
        check("midrst_pin_clk_out", pin_clk_out, 1);
        check("midrst_pin_data_out", pin_data_out, 1);
        check("midrst_pin_clk_oe", pin_clk_oe, 0);
        check("midrst_owner_host", owner_host, 0);
        check("midrst_host_rx", host_rx, 8'h00);
        rst = 1'b0;
        repeat (4300) @(negedge clk_sys);

        check("pending_events", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
